// File: rtl/checker_logic.sv
// -----------------------------------------------------------------------------
// checker_logic
//
// Stream sink and data checker for valid/ready test benches. Accepts a DW-bit
// stream whose payload should be an incrementing count starting at 0, throttles
// its own ready with a programmable inter-beat delay, checks every accepted
// beat and reports beat count, error count and first-failure context.
//
// Parameters:
//   DW     data width of the checked stream
//   DELAY  idle cycles inserted between accepted beats (0 = ready every cycle)
//
// Ports:
//   clk            clock, all state changes on rising edge
//   rst            asynchronous active-high reset
//   up_valid       upstream beat valid
//   up_data        upstream beat payload (sampled only on a handshake)
//   up_ready       sink ready, decoded from registers only
//   beat_cnt       accepted-beat counter, wraps modulo 2^32
//   err_cnt        mismatch counter, saturates at 16'hFFFF
//   mismatch       one-cycle pulse the cycle after a mismatching handshake
//   ok             high while in RUN (no mismatch seen since reset)
//   first_err_exp  expected value at the first mismatch
//   first_err_got  received value at the first mismatch
// -----------------------------------------------------------------------------
module checker_logic #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DELAY = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic [31:0]   beat_cnt,
  output logic [15:0]   err_cnt,
  output logic          mismatch,
  output logic          ok,
  output logic [DW-1:0] first_err_exp,
  output logic [DW-1:0] first_err_got
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [15:0]   DELAY_CNT = 16'(DELAY);
  localparam logic [DW-1:0] DATA_ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

  state_t        state;
  logic [15:0]   stall_cnt;
  logic [DW-1:0] exp_data;
  logic          stall_done;
  logic          handshake;
  logic          data_bad;

  // Full-width payload compare; wrap from all-ones to zero is handled by the
  // modular increment that produces the expected value.
  function automatic logic beat_matches(input logic [DW-1:0] got,
                                        input logic [DW-1:0] want);
    return (got == want);
  endfunction

  assign stall_done = (stall_cnt == DELAY_CNT);
  // Ready never looks at up_valid, so it cannot form a combinational loop
  // with an upstream source that waits for ready.
  assign up_ready   = (state != IDLE) && stall_done;
  assign handshake  = up_valid && up_ready;
  assign data_bad   = handshake && !beat_matches(up_data, exp_data);

  // Control FSM with registered ok flag; ERR is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ok    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          ok    <= 1'b1;
        end
        RUN: begin
          if (data_bad) begin
            state <= ERR;
            ok    <= 1'b0;
          end else begin
            state <= RUN;
            ok    <= 1'b1;
          end
        end
        ERR: begin
          state <= ERR;
          ok    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ok    <= 1'b0;
        end
      endcase
    end
  end

  // Ready throttle: count idle cycles after each beat up to DELAY, then hold
  // at DELAY (ready high) until a beat actually transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (handshake) begin
      stall_cnt <= 16'd0;
    end else if ((state != IDLE) && (stall_cnt < DELAY_CNT)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  // Expected value tracks the last received beat plus one, so a single
  // skipped value costs one error instead of a cascade.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_data <= DATA_ZERO;
    end else if (handshake) begin
      exp_data <= up_data + DATA_ONE;
    end else begin
      exp_data <= exp_data;
    end
  end

  // Beat counter, free-running modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= 32'd0;
    end else if (handshake) begin
      beat_cnt <= beat_cnt + 32'd1;
    end else begin
      beat_cnt <= beat_cnt;
    end
  end

  // Error counter saturating at all-ones, plus the one-cycle mismatch pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt  <= 16'd0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= data_bad;
      if (data_bad && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end else begin
        err_cnt <= err_cnt;
      end
    end
  end

  // First-failure capture; err_cnt == 0 marks that nothing was captured yet,
  // and saturation guarantees it never returns to zero before reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_exp <= DATA_ZERO;
      first_err_got <= DATA_ZERO;
    end else if (data_bad && (err_cnt == 16'd0)) begin
      first_err_exp <= exp_data;
      first_err_got <= up_data;
    end else begin
      first_err_exp <= first_err_exp;
      first_err_got <= first_err_got;
    end
  end

endmodule
